mmio_display_ctrl: RTL

MMIO_DISPLAY_CTRL -- requirements
Module: mmio_display_ctrl

---
 rtl/mmio_display_ctrl_pkg.sv | 21 ++
 rtl/mmio_display_ctrl_dec.sv | 9 +
 rtl/mmio_display_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/mmio_display_ctrl_pkg.sv
// mmio_display_ctrl_pkg: register offsets, CTRL bit positions and the hex segment table.
package mmio_display_ctrl_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_LZB = 1;
  localparam int CTRL_DP  = 8;
  // Active-low a..g in bits 0..6 for hex values 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/mmio_display_ctrl_dec.sv
// hex7seg_dec: 4-bit hex value to active-low 7-segment pattern.
module hex7seg_dec
  import mmio_display_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/mmio_display_ctrl.sv
// mmio_display_ctrl: memory-mapped multiplexed 7-segment display controller.
// Leading-zero blanking is built only when DISPLAY_LZ_BLANK_EN is defined.
module mmio_display_ctrl
  import mmio_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 25000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [3:0]            wbe,
  input  logic [1:0]            address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic [7:0]            segments,
  output logic [NUM_DIGITS-1:0] display_en_n
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [31:0] DMASK = 32'((64'd1 << (4*NUM_DIGITS)) - 64'd1);
  logic [31:0]   data_q;
  logic          en_q;
  logic          lzb_q;
  logic [7:0]    dp_q;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   ctrl_rd;
  logic [6:0]    seg;
  logic          blank;
  logic          wr_data;
  logic          wr_ctrl;
  assign wr_data = ce && (|wbe) && address == ADDR_DATA;
  assign wr_ctrl = ce && (|wbe) && address == ADDR_CTRL;
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN] = en_q;
    ctrl_rd[CTRL_LZB] = lzb_q;
    ctrl_rd[CTRL_DP +: 8] = dp_q;
  end
  assign data_out = !ce ? 32'd0 :
                    address == ADDR_DATA   ? data_q :
                    address == ADDR_CTRL   ? ctrl_rd :
                    address == ADDR_STATUS ? {29'd0, idx} : 32'd0;
  hex7seg_dec u_dec (.hex(data_q[{idx, 2'b00} +: 4]), .seg(seg));
  // A digit is a leading zero when it and every higher nibble are zero.
  assign blank = lzb_q && (idx != 3'd0) && ((data_q >> {idx, 2'b00}) == 32'd0);
`ifdef DISPLAY_LZ_BLANK_EN
  always_ff @(posedge clk)
    if (!rst_n) lzb_q <= 1'b0;
    else if (wr_ctrl && wbe[CTRL_LZB/8]) lzb_q <= data_in[CTRL_LZB];
`else
  assign lzb_q = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q       <= '0;
      en_q         <= 1'b0;
      dp_q         <= '0;
      presc        <= '0;
      idx          <= '0;
      segments     <= 8'hFF;
      display_en_n <= '1;
    end else begin
      if (wr_data) data_q <= byte_merge(data_q, data_in, wbe) & DMASK;
      if (wr_ctrl && wbe[CTRL_EN/8]) en_q <= data_in[CTRL_EN];
      if (wr_ctrl && wbe[CTRL_DP/8]) dp_q <= data_in[CTRL_DP +: 8];
      // Disabled scan parks at zero, so re-enabling always starts at digit 0.
      if (!en_q) begin
        presc <= '0;
        idx   <= '0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      segments     <= en_q ? {~dp_q[idx], blank ? 7'h7F : seg} : 8'hFF;
      display_en_n <= en_q ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end
endmodule
